// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
//   state_t        : FSM state encoding (IDLE, BUSY, DONE)
//   calc_ndig()    : digit cycles per operation; returns 0 when DIGIT_W does
//                    not divide WIDTH so the top can stop elaboration
//   cnt_width()    : digit counter width, $clog2(NDIG) with a minimum of 1
//   CNT_W_DEFAULT  : counter width for the default 8-bit / 2-bit build
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned calc_ndig(input int unsigned width,
                                             input int unsigned digit_w);
      if (digit_w == 0 || (width % digit_w) != 0)
         return 0;
      return width / digit_w;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

   localparam int unsigned CNT_W_DEFAULT = cnt_width(calc_ndig(8, 2));

endpackage

// File: rtl/sub_digit.sv
// One digit of the subtract chain: {bout, d} = a - b - bin at DIGIT_W+1 bits.
//   i_a, i_b : DIGIT_W-bit operand digits
//   i_bin    : borrow in from the previous (lower) digit
//   o_d      : difference digit
//   o_bout   : borrow out to the next (higher) digit
module sub_digit
   import sub_pkg::*;
#(
   parameter int unsigned DIGIT_W = 2
) (
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   input  logic               i_bin,
   output logic [DIGIT_W-1:0] o_d,
   output logic               o_bout
);

   localparam int unsigned EXT_W = DIGIT_W + 1;

   logic [EXT_W-1:0] w_ext;

   // The extra top bit becomes 1 exactly when the digit underflows.
   assign w_ext  = {1'b0, i_a} - {1'b0, i_b} - EXT_W'(i_bin);
   assign o_d    = w_ext[DIGIT_W-1:0];
   assign o_bout = w_ext[DIGIT_W];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor, DIGIT_W bits per cycle, LSB digit first.
// diff = (a - b) mod 2^WIDTH, borrow = (a < b). Valid/ready on both sides;
// one operation in flight, out_valid rises NDIG edges after the accept edge.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_ready only in IDLE)
//   a, b               : minuend, subtrahend
//   out_valid/out_ready: result handshake
//   diff, borrow       : registered result, updated only on entry to DONE
// Build option: define SUB_SAT_EN to clamp diff to 0 whenever borrow is set.
module digit_serial_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIGIT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT_W);
   localparam int unsigned CNT_W = cnt_width(NDIG);

   if (NDIG == 0) begin : g_bad_digit_w
      $error("digit_serial_subtractor: DIGIT_W must divide WIDTH exactly");
   end

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_bin;
   logic [WIDTH-1:0]   r_res;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;

   logic [DIGIT_W-1:0] w_d;
   logic               w_bout;
   logic [WIDTH-1:0]   w_res_next;
   logic [WIDTH-1:0]   w_diff_final;

   sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
      .i_a    (r_a[DIGIT_W-1:0]),
      .i_b    (r_b[DIGIT_W-1:0]),
      .i_bin  (r_bin),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
   assign w_res_next = (r_res >> DIGIT_W) | (WIDTH'(w_d) << (WIDTH - DIGIT_W));

`ifdef SUB_SAT_EN
   assign w_diff_final = w_bout ? '0 : w_res_next;
`else
   assign w_diff_final = w_res_next;
`endif

   // Control FSM plus operand/result shift registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_bin       <= 1'b0;
         r_res       <= '0;
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_bin   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_a   <= r_a >> DIGIT_W;
               r_b   <= r_b >> DIGIT_W;
               r_res <= w_res_next;
               r_bin <= w_bout;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(NDIG - 1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_diff      <= w_diff_final;
                  r_borrow    <= w_bout;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign borrow    = r_borrow;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor (WIDTH=8, DIGIT_W=2).
// Expected results are hand-computed; the SUB_SAT_EN build clamps them.
module tb_digit_serial_subtractor;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NDIG  = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   int n_vec;
   int n_err;

   digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] exp_diff(input logic [WIDTH-1:0] raw,
                                                 input logic brw);
`ifdef SUB_SAT_EN
      return brw ? '0 : raw;
`else
      return brw ? raw : raw;
`endif
   endfunction

   // Present operands in IDLE, wait for the result, check it, then hand it off.
   task automatic run_op(input string name, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] raw,
                         input logic brw);
      int cyc;
      logic [WIDTH-1:0] ed;
      ed = exp_diff(raw, brw);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_ready_before: got %0b want 1", name, in_ready);
      end
      a = va; b = vb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_vec++;
      if (cyc !== NDIG) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, NDIG);
      end
      n_vec++;
      if (diff !== ed) begin
         n_err++;
         $display("FAIL %s diff: got 0x%02h want 0x%02h", name, diff, ed);
      end
      n_vec++;
      if (borrow !== brw) begin
         n_err++;
         $display("FAIL %s borrow: got %0b want %0b", name, borrow, brw);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s handoff: got out_valid=%0b in_ready=%0b want 0/1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got in_ready=%0b out_valid=%0b diff=0x%02h borrow=%0b want 1/0/00/0",
                  in_ready, out_valid, diff, borrow);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      run_op("a200_b55",   8'd200, 8'd55,  8'd145, 1'b0);
      run_op("a55_b200",   8'd55,  8'd200, 8'h6F,  1'b1);
      run_op("a0_b1",      8'h00,  8'h01,  8'hFF,  1'b1);
      run_op("aAA_bAA",    8'hAA,  8'hAA,  8'h00,  1'b0);
      run_op("a0_bFF",     8'h00,  8'hFF,  8'h01,  1'b1);
      run_op("aFF_b0",     8'hFF,  8'h00,  8'hFF,  1'b0);
   endtask

   task automatic test_backpressure();
      int cyc;
      a = 8'h80; b = 8'h01; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || diff !== 8'h7F || borrow !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_hold%0d: got ov=%0b diff=0x%02h borrow=%0b ir=%0b want 1/7f/0/0",
                     i, out_valid, diff, borrow, in_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL backpressure_release: got ov=%0b ir=%0b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_ignore_busy();
      int seen;
      a = 8'd100; b = 8'd30; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_in_ready: got %0b want 0", in_ready);
      end
      a = 8'd9; b = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && seen < 20) begin
         @(posedge clk); #1;
         seen++;
      end
      n_vec++;
      if (diff !== 8'd70 || borrow !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_result: got diff=%0d borrow=%0b want 70/0", diff, borrow);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL ignore_no_second: got %0d valid cycles want 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      a = 8'h33; b = 8'h11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_state: got ov=%0b diff=0x%02h borrow=%0b ir=%0b want 0/00/0/1",
                  out_valid, diff, borrow, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < NDIG + 2; i++) begin
         if (out_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL midreset_discard: got %0d valid cycles want 0", seen);
      end
      run_op("after_reset_a10_b4", 8'd10, 8'd4, 8'd6, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_ignore_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
